// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 transmitter: inhibit, start bit, 8 data LSB-first, odd parity, stop, ack sample.
// Latency: INHIBIT_CYCLES of clock inhibit, then one bit per device clock; done/error one edge after the 11th fall.
// Backpressure: send_req is accepted only in IDLE; requests while busy are dropped, not queued.
module ps2_transmitter #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    input  logic [7:0] i_send_data,
    input  logic       i_send_req,
    output logic       o_busy,
    output logic       o_send_done,
    output logic       o_send_error,
    output logic       o_ps2_clk_drive_low,
    output logic       o_ps2_data_drive_low
);

    // One counter serves both the inhibit interval and the frame timeout.
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SHIFT,
        S_WAIT_IDLE
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic            r_clk_meta;
    logic            r_clk_sync;
    logic            r_clk_prev;
    logic            r_dat_meta;
    logic            r_dat_sync;
    logic            w_fall;

    // Frame is consumed as a shift register: bit 0 is always the bit on the wire.
    logic [9:0]      r_frame;
    logic [3:0]      r_bitcnt;
    logic [CW-1:0]   r_cnt;
    logic            r_done;
    logic            r_error;

    logic            w_timeout;
    logic            w_last_fall;

    assign w_fall      = r_clk_prev & ~r_clk_sync;
    assign w_timeout   = ((r_state == S_START) || (r_state == S_SHIFT)) && (r_cnt == TO_LAST);
    assign w_last_fall = (r_state == S_SHIFT) && w_fall && (r_bitcnt == 4'd10);

    assign o_send_done  = r_done;
    assign o_send_error = r_error;

    // Two-flop synchronisers for the bus pins plus a delayed clock copy for fall detection.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= i_ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= i_ps2_data;
            r_dat_sync <= r_dat_meta;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and pin drive decode; outputs are pure functions of state so reset clears them at once.
    always_comb begin
        w_next_state         = r_state;
        o_busy               = 1'b1;
        o_ps2_clk_drive_low  = 1'b0;
        o_ps2_data_drive_low = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_send_req) begin
                    w_next_state = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                o_ps2_clk_drive_low = 1'b1;
                if (r_cnt == INH_LAST) begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                o_ps2_data_drive_low = 1'b1;
                if (w_timeout) begin
                    w_next_state = S_WAIT_IDLE;
                end else if (w_fall) begin
                    w_next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                o_ps2_data_drive_low = ~r_frame[0];
                if (w_timeout || w_last_fall) begin
                    w_next_state = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (r_clk_sync && r_dat_sync) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Frame latch, bit shifting, inhibit/timeout counting and the done/error pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_frame  <= '0;
            r_bitcnt <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_send_req) begin
                        r_frame  <= {1'b1, ~^i_send_data, i_send_data};
                        r_bitcnt <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_INHIBIT: begin
                    if (r_cnt == INH_LAST) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_START: begin
                    if (w_timeout) begin
                        r_error <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        if (w_fall) begin
                            r_bitcnt <= 4'd1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (w_timeout) begin
                        r_error <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        if (w_fall) begin
                            if (r_bitcnt == 4'd10) begin
                                r_done  <= ~r_dat_sync;
                                r_error <= r_dat_sync;
                            end else begin
                                r_frame  <= {1'b1, r_frame[9:1]};
                                r_bitcnt <= r_bitcnt + 4'd1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_transmitter.sv
// Scoreboard bench for ps2_transmitter with an open-drain PS/2 device model.
// Stimulus pushes expected outcomes; a negedge monitor pops them on each done/error pulse.
// The device model clocks the bus and records the 11 bits it samples (start..stop).
module tb_ps2_transmitter;

    localparam int INH = 10;
    localparam int TO  = 500;
    localparam int H   = 20;   // device clock half-period in system clocks

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [7:0] sdata;
    logic       busy, done, err, cdl, ddl;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_pin, ps2_data_pin;

    logic       dev_ack_high = 1'b0;
    logic       dev_silent   = 1'b0;
    logic [10:0] dev_cap = '1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        is_done;
        logic        chk_frame;
        logic [10:0] frame;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    assign ps2_clk_pin  = ~cdl & dev_clk;
    assign ps2_data_pin = ~ddl & dev_dat;

    ps2_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk                (clk),
        .i_reset              (rst),
        .i_ps2_clk            (ps2_clk_pin),
        .i_ps2_data           (ps2_data_pin),
        .i_send_data          (sdata),
        .i_send_req           (req),
        .o_busy               (busy),
        .o_send_done          (done),
        .o_send_error         (err),
        .o_ps2_clk_drive_low  (cdl),
        .o_ps2_data_drive_low (ddl)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic push, input logic is_done,
                        input logic chk, input logic [10:0] frame);
        exp_t e;
        @(negedge clk);
        sdata = d;
        req   = 1'b1;
        if (push) begin
            e.is_done   = is_done;
            e.chk_frame = chk;
            e.frame     = frame;
            sb.push_back(e);
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 3000 && busy; k++) @(negedge clk);
        check(name, 32'(busy), 32'd0);
    endtask

    // Device model: sees inhibit release with data low, then clocks 11 times and acks.
    initial begin
        forever begin
            @(negedge clk);
            if (cdl) begin
                while (cdl) @(negedge clk);
                dev_cap    = '1;
                dev_cap[0] = ps2_data_pin;
                if (!dev_silent) begin
                    repeat (10) @(negedge clk);
                    for (int i = 1; i <= 10; i++) begin
                        dev_clk = 1'b0;
                        repeat (H) @(negedge clk);
                        dev_cap[i] = ps2_data_pin;
                        dev_clk = 1'b1;
                        repeat (H) @(negedge clk);
                    end
                    repeat (H / 2) @(negedge clk);
                    dev_dat = dev_ack_high;
                    repeat (H / 2) @(negedge clk);
                    dev_clk = 1'b0;
                    repeat (H) @(negedge clk);
                    dev_clk = 1'b1;
                    repeat (H / 2) @(negedge clk);
                    dev_dat = 1'b1;
                end
            end
        end
    end

    // Monitor: pulse scoreboard, inhibit length, idle lines at busy fall.
    int   inh_run   = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done || err) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: done=%0b error=%0b, expected no pulse", done, err);
                end else begin
                    e = sb.pop_front();
                    check("pulse_done", 32'(done), 32'(e.is_done));
                    check("pulse_error", 32'(err), 32'(!e.is_done));
                    if (e.chk_frame) check("device_frame", 32'(dev_cap), 32'(e.frame));
                end
            end
            if (cdl) begin
                inh_run++;
            end else if (inh_run != 0) begin
                check("inhibit_len", 32'(inh_run), 32'(INH));
                inh_run = 0;
            end
            if (prev_busy && !busy) begin
                check("idle_lines_at_busy_fall", 32'({ps2_clk_pin, ps2_data_pin}), 32'd3);
            end
        end
        prev_busy = busy;
    end

    // Watchdog so the run always ends.
    initial begin
        #(20000 * 10);
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int k;
        rst   = 1'b1;
        req   = 1'b0;
        sdata = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_error", 32'(err), 32'd0);
        check("reset_clk_drive", 32'(cdl), 32'd0);
        check("reset_data_drive", 32'(ddl), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 0xED: data 1,0,1,1,0,1,1,1 parity 1 stop 1, acked
        send(8'hED, 1'b1, 1'b1, 1'b1, 11'b11111011010);
        wait_idle("idle_after_ED");
        // 0xF4: data 0,0,1,0,1,1,1,1 parity 0 stop 1, acked
        send(8'hF4, 1'b1, 1'b1, 1'b1, 11'b10111101000);
        wait_idle("idle_after_F4");
        // 0x55 with device holding data high at ack: error
        dev_ack_high = 1'b1;
        send(8'h55, 1'b1, 1'b0, 1'b1, 11'b11010101010);
        wait_idle("idle_after_nack");
        dev_ack_high = 1'b0;

        // 0xA3 with a 0x00 re-request mid-frame, which must be ignored
        send(8'hA3, 1'b1, 1'b1, 1'b1, 11'b11101000110);
        repeat (INH + 150) @(negedge clk);
        check("busy_mid_frame", 32'(busy), 32'd1);
        sdata = 8'h00;
        req   = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_idle("idle_after_rereq");
        repeat (10) @(negedge clk);
        check("no_accept_after_rereq", 32'(busy), 32'd0);

        // Silent device: timeout 500 cycles after START
        dev_silent = 1'b1;
        send(8'h12, 1'b1, 1'b0, 1'b0, 11'h000);
        for (k = 0; k < 100 && !ddl; k++) @(negedge clk);
        check("start_bit_driven", 32'(ddl), 32'd1);
        for (k = 0; k < 1000 && !err; k++) @(negedge clk);
        check("timeout_latency", 32'(k), 32'(TO));
        check("timeout_clk_released", 32'(cdl), 32'd0);
        check("timeout_data_released", 32'(ddl), 32'd0);
        wait_idle("idle_after_timeout");
        dev_silent = 1'b0;
        repeat (5) @(negedge clk);

        // Reset during SHIFT: outputs clear next edge, no pulse afterwards
        send(8'h3C, 1'b0, 1'b0, 1'b0, 11'h000);
        for (k = 0; k < 100 && !ddl; k++) @(negedge clk);
        repeat (100) @(negedge clk);
        check("busy_before_reset", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_error", 32'(err), 32'd0);
        check("midrst_clk_drive", 32'(cdl), 32'd0);
        check("midrst_data_drive", 32'(ddl), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (600) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("idle_at_end", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
